// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

    // Packer control states: normal filling, waiting for a read to land, emitting a partial word.
    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } pk_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK       = 4;
    localparam int MAX_PACK       = 16;

    // Lane enable vector: bit i is set when lane i holds a valid entry.
    function automatic logic [MAX_PACK-1:0] lane_mask(input int unsigned count);
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PACK; i++) begin
            m[i] = (i < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pulls entries from the FIFO read port and packs PACK of them into one wide
// word presented on a valid/ready interface; FLUSH drains a partial word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK       = DEF_PACK,
    parameter int CNT_W      = $clog2(PACK + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REMPTY,
    input  logic [DATA_WIDTH-1:0]      RDATA,
    output logic                       R_INC,
    input  logic                       FLUSH,
    output logic [DATA_WIDTH*PACK-1:0] OUT_DATA,
    output logic [CNT_W-1:0]           OUT_COUNT,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic                       FLUSH_BUSY
);

    localparam logic [CNT_W-1:0] PACK_C  = CNT_W'(PACK);
    localparam logic [CNT_W-1:0] PACK_M1 = CNT_W'(PACK - 1);

    pk_state_t                 state_q, state_d;
    logic [DATA_WIDTH*PACK-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]          acc_cnt_q, acc_cnt_d;
    logic                      inflight_q;
    logic [DATA_WIDTH*PACK-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]          out_count_q, out_count_d;
    logic                      out_valid_q, out_valid_d;

    logic                      out_free;
    logic [CNT_W-1:0]          cnt_land;
    logic [PACK-1:0]           lane_en;
    logic                      load_full;
    logic                      load_flush;
    logic                      rd_room;
    logic                      rd_chain;

    // Accumulator capture and output-register load for this edge.
    always_comb begin
        out_free = !out_valid_q || OUT_READY;
        // An in-flight read lands this edge, so it counts toward the word now.
        cnt_land = acc_cnt_q + {{(CNT_W-1){1'b0}}, inflight_q};

        acc_d = acc_q;
        for (int i = 0; i < PACK; i++) begin
            if (inflight_q && (acc_cnt_q == CNT_W'(i))) begin
                acc_d[i*DATA_WIDTH +: DATA_WIDTH] = RDATA;
            end
        end

        load_full  = (cnt_land == PACK_C) && out_free;
        load_flush = (state_q == FLUSH_EMIT) && out_free;

        acc_cnt_d   = cnt_land;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q && !OUT_READY;
        lane_en     = PACK'(lane_mask(32'(cnt_land)));

        if (load_full || load_flush) begin
            out_data_d = acc_d;
            // Stale lanes from the previous word must not leak into a partial word.
            for (int i = 0; i < PACK; i++) begin
                if (!lane_en[i]) begin
                    out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end
            end
            out_count_d = cnt_land;
            out_valid_d = 1'b1;
            acc_cnt_d   = '0;
        end
    end

    // Next-state logic for the flush sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (FLUSH) state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                // Decide on the post-edge count so a word completing now is not re-emitted empty.
                if (!inflight_q) state_d = (acc_cnt_d == '0) ? FILL : FLUSH_EMIT;
            end
            FLUSH_EMIT: begin
                if (out_free) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Read request and busy flag; reads are only issued while filling and never during reset.
    always_comb begin
        rd_room    = ({1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, inflight_q}) < {1'b0, PACK_C};
        rd_chain   = (acc_cnt_q == PACK_M1) && inflight_q && out_free;
        R_INC      = !RST && (state_q == FILL) && !FLUSH && !REMPTY && (rd_room || rd_chain);
        FLUSH_BUSY = (state_q != FILL);
    end

    // State, accumulator and output register update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= FILL;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            inflight_q  <= R_INC;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_COUNT = out_count_q;
    assign OUT_VALID = out_valid_q;

endmodule
